axil_aw_arbiter_rr: RTL

//  Clocked, parametrised AXI-Lite write-address (AW) arbiter for the N-master interconnect.

---
 rtl/axil_ic_pkg.sv | 25 ++
 rtl/axil_rr_arbiter.sv | 32 +++
 rtl/axil_aw_arbiter_rr.sv | 114 +++++++++++
 3 files changed

// File: rtl/axil_ic_pkg.sv
// rtl/axil_ic_pkg.sv - shared types, widths and helpers for the AXI-Lite interconnect arbiters
package axil_ic_pkg;

  localparam int AXI_PROT_W    = 3;
  localparam int AXI_QOS_W     = 4;
  // Widest request vector the index helper can encode.
  localparam int ARB_MAX_PORTS = 64;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_FULL = 1'b1
  } arb_state_t;

  // One-hot to binary index; OR-ing the indices of set bits is exact for one-hot input
  // and collapses to a small OR tree in hardware.
  function automatic logic [5:0] onehot_to_idx(input logic [ARB_MAX_PORTS-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// rtl/axil_rr_arbiter.sv - combinational round-robin arbiter (masked/unmasked double priority encode)
module axil_rr_arbiter
  import axil_ic_pkg::*;
#(
  parameter  int N    = 16,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_unmasked;

  // Keep only requesters at or above the pointer; lowest set bit of each vector wins.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i >= int'(ptr));
    end
    req_masked   = req & upper_mask;
    gnt_masked   = req_masked & (~req_masked + N'(1));
    gnt_unmasked = req & (~req + N'(1));
    gnt          = (|req_masked) ? gnt_masked : gnt_unmasked;
    gnt_idx      = ID_W'(onehot_to_idx(ARB_MAX_PORTS'(gnt)));
  end

endmodule

// File: rtl/axil_aw_arbiter_rr.sv
// rtl/axil_aw_arbiter_rr.sv - round-robin AXI-Lite AW arbiter with one-entry output register (optional AW_ARB_QOS_EN)
module axil_aw_arbiter_rr
  import axil_ic_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int NUM_MASTERS = 16,
  localparam int ID_WIDTH    = $clog2(NUM_MASTERS)
) (
  input  logic                              m_axi_aclk_i,
  input  logic                              m_axi_aresetn_i,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_axi_awaddr_i,
  input  logic [AXI_PROT_W*NUM_MASTERS-1:0] m_axi_awprot_i,
  input  logic [NUM_MASTERS-1:0]            m_axi_awvalid_i,
  output logic [NUM_MASTERS-1:0]            m_axi_awready_o,
  output logic [ADDR_WIDTH-1:0]             s_axi_awaddr_o,
  output logic [AXI_PROT_W-1:0]             s_axi_awprot_o,
  output logic                              s_axi_awvalid_o,
  input  logic                              s_axi_awready_i,
  output logic [NUM_MASTERS-1:0]            Master_ID_Selected_o,
  output logic [ID_WIDTH-1:0]               master_id_o
`ifdef AW_ARB_QOS_EN
  ,
  input  logic [AXI_QOS_W*NUM_MASTERS-1:0]  m_axi_awqos_i
`endif
);

  arb_state_t                 state_q;
  arb_state_t                 state_d;
  logic [ID_WIDTH-1:0]        ptr_q;
  logic [ID_WIDTH-1:0]        ptr_next;
  logic [NUM_MASTERS-1:0]     req_eff;
  logic [NUM_MASTERS-1:0]     gnt;
  logic [ID_WIDTH-1:0]        gnt_idx;
  logic                       can_accept;
  logic                       take;

`ifdef AW_ARB_QOS_EN
  logic [AXI_QOS_W-1:0] qos_max;

  // Restrict the candidate set to requesters carrying the highest QoS value.
  always_comb begin
    qos_max = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (m_axi_awvalid_i[k] && (m_axi_awqos_i[k*AXI_QOS_W +: AXI_QOS_W] > qos_max)) begin
        qos_max = m_axi_awqos_i[k*AXI_QOS_W +: AXI_QOS_W];
      end
    end
    req_eff = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      req_eff[k] = m_axi_awvalid_i[k] && (m_axi_awqos_i[k*AXI_QOS_W +: AXI_QOS_W] == qos_max);
    end
  end
`else
  assign req_eff = m_axi_awvalid_i;
`endif

  axil_rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr (
    .req     (req_eff),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Entry can take a new beat when empty, or when the held beat leaves this cycle.
  always_comb begin
    state_d    = state_q;
    can_accept = 1'b0;
    case (state_q)
      ARB_IDLE: can_accept = 1'b1;
      ARB_FULL: can_accept = s_axi_awready_i;
      default:  can_accept = 1'b0;
    endcase
    take = can_accept && (|req_eff);
    if (take) begin
      state_d = ARB_FULL;
    end else if ((state_q == ARB_FULL) && s_axi_awready_i) begin
      state_d = ARB_IDLE;
    end
  end

  // Gate with reset so no master sees a handshake while the block is held in reset.
  assign m_axi_awready_o = gnt & {NUM_MASTERS{take && m_axi_aresetn_i}};
  assign s_axi_awvalid_o = (state_q == ARB_FULL);
  assign ptr_next        = (gnt_idx == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

  // State register.
  always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
    if (!m_axi_aresetn_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's beat and ID, and advance the pointer past it, on every master handshake.
  always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
    if (!m_axi_aresetn_i) begin
      s_axi_awaddr_o       <= '0;
      s_axi_awprot_o       <= '0;
      Master_ID_Selected_o <= '0;
      master_id_o          <= '0;
      ptr_q                <= '0;
    end else if (take) begin
      s_axi_awaddr_o       <= m_axi_awaddr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      s_axi_awprot_o       <= m_axi_awprot_i[gnt_idx*AXI_PROT_W +: AXI_PROT_W];
      Master_ID_Selected_o <= gnt;
      master_id_o          <= gnt_idx;
      ptr_q                <= ptr_next;
    end
  end

endmodule
